// File: rtl/pipeline_hazard_sequencer_if.sv
// pipeline_hazard_sequencer_if: hazard inputs from ID/EX/MEM and stall/flush controls back to the pipeline
interface pipeline_hazard_sequencer_if #(
   parameter int REG_W = 5,
   parameter int CNT_W = 16
);
   logic [REG_W-1:0] ID_rs1_i, ID_rs2_i, EX_rd_i;
   logic             EX_MemRead_i, Branch_taken_i, MEM_req_i, MEM_ack_i;
   logic             PCWrite_o, IFIDWrite_o, NoOp_o, Flush_o, PipeStall_o, Err_o;
   logic [1:0]       State_o;
   logic [CNT_W-1:0] LoadUseCnt_o, MemWaitCnt_o, FlushCnt_o;
   modport master (
      output ID_rs1_i, ID_rs2_i, EX_rd_i, EX_MemRead_i, Branch_taken_i, MEM_req_i, MEM_ack_i,
      input  PCWrite_o, IFIDWrite_o, NoOp_o, Flush_o, PipeStall_o, Err_o, State_o,
             LoadUseCnt_o, MemWaitCnt_o, FlushCnt_o
   );
   modport slave (
      input  ID_rs1_i, ID_rs2_i, EX_rd_i, EX_MemRead_i, Branch_taken_i, MEM_req_i, MEM_ack_i,
      output PCWrite_o, IFIDWrite_o, NoOp_o, Flush_o, PipeStall_o, Err_o, State_o,
             LoadUseCnt_o, MemWaitCnt_o, FlushCnt_o
   );
endinterface

// File: rtl/pipeline_hazard_sequencer.sv
// pipeline_hazard_sequencer: load-use bubbles, memory-wait freezes with timeout error, branch flushes.
// Define STALL_PERF_EN to build the saturating load-use / mem-wait / flush counters.
module pipeline_hazard_sequencer #(
   parameter int REG_W   = 5,
   parameter int TIMEOUT = 16,
   parameter int CNT_W   = 16
) (
   input logic                        clk_i,
   input logic                        rst_i,
   pipeline_hazard_sequencer_if.slave hz
);
   typedef enum logic [1:0] {RUN = 2'd0, MEM_WAIT = 2'd1, ERROR = 2'd2} state_e;
   state_e           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             lu, mw, halt, noop, flush;
   always_comb begin
      lu = hz.EX_MemRead_i && hz.EX_rd_i != REG_W'(0) &&
           (hz.EX_rd_i == hz.ID_rs1_i || hz.EX_rd_i == hz.ID_rs2_i);
      mw = (state_q == MEM_WAIT || (state_q == RUN && hz.MEM_req_i)) && !hz.MEM_ack_i;
      halt = state_q == ERROR || mw;
      noop = !halt && lu;
      flush = !halt && !lu && hz.Branch_taken_i;
      state_d = state_q;
      cnt_d = cnt_q;
      case (state_q)
         RUN: if (mw) begin
            state_d = MEM_WAIT;
            cnt_d = CNT_W'(1);
         end
         MEM_WAIT: if (hz.MEM_ack_i) begin
            state_d = RUN;
            cnt_d = '0;
         end else if (cnt_q == CNT_W'(TIMEOUT)) begin
            state_d = ERROR;
         end else begin
            cnt_d = cnt_q + CNT_W'(1);
         end
         default: ;
      endcase
   end
   always_ff @(posedge clk_i) begin
      state_q <= rst_i ? RUN : state_d;
      cnt_q <= rst_i ? '0 : cnt_d;
   end
   assign hz.PCWrite_o = !halt && !lu;
   assign hz.IFIDWrite_o = !halt && !lu;
   assign hz.NoOp_o = noop;
   assign hz.Flush_o = flush;
   assign hz.PipeStall_o = halt;
   assign hz.Err_o = state_q == ERROR;
   assign hz.State_o = state_q;
`ifdef STALL_PERF_EN
   logic [CNT_W-1:0] lu_cnt_q, mw_cnt_q, fl_cnt_q;
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         lu_cnt_q <= '0;
         mw_cnt_q <= '0;
         fl_cnt_q <= '0;
      end else begin
         if (noop && lu_cnt_q != '1) lu_cnt_q <= lu_cnt_q + CNT_W'(1);
         if (mw && mw_cnt_q != '1) mw_cnt_q <= mw_cnt_q + CNT_W'(1);
         if (flush && fl_cnt_q != '1) fl_cnt_q <= fl_cnt_q + CNT_W'(1);
      end
   end
   assign hz.LoadUseCnt_o = lu_cnt_q;
   assign hz.MemWaitCnt_o = mw_cnt_q;
   assign hz.FlushCnt_o = fl_cnt_q;
`else
   assign hz.LoadUseCnt_o = '0;
   assign hz.MemWaitCnt_o = '0;
   assign hz.FlushCnt_o = '0;
`endif
endmodule

// File: tb/tb_pipeline_hazard_sequencer.sv
// tb_pipeline_hazard_sequencer: directed scenarios plus random traffic against a cycle-level reference model
module tb_pipeline_hazard_sequencer;
   localparam int TO = 4;
   logic clk = 0, rst = 1;
   int total = 0, bad = 0;
   int m_waited = 0, m_lu = 0, m_mw = 0, m_fl = 0;
   bit m_err = 0;
   always #5 clk = ~clk;
   pipeline_hazard_sequencer_if #(.REG_W(5), .CNT_W(16)) hz ();
   pipeline_hazard_sequencer #(.REG_W(5), .TIMEOUT(TO), .CNT_W(16)) dut (
      .clk_i(clk), .rst_i(rst), .hz(hz.slave)
   );
   // {State[1:0], PCWrite, IFIDWrite, NoOp, Flush, PipeStall, Err}
   function automatic logic [7:0] model_out();
      bit lu, mw;
      logic [1:0] st;
      lu = hz.EX_MemRead_i && hz.EX_rd_i != 5'd0 &&
           (hz.EX_rd_i == hz.ID_rs1_i || hz.EX_rd_i == hz.ID_rs2_i);
      mw = !m_err && (m_waited > 0 || hz.MEM_req_i) && !hz.MEM_ack_i;
      st = m_err ? 2'd2 : (m_waited > 0 ? 2'd1 : 2'd0);
      if (m_err) return {st, 6'b000011};
      if (mw) return {st, 6'b000010};
      if (lu) return {st, 6'b001000};
      if (hz.Branch_taken_i) return {st, 6'b110100};
      return {st, 6'b110000};
   endfunction
   function automatic logic [7:0] obs();
      return {hz.State_o, hz.PCWrite_o, hz.IFIDWrite_o, hz.NoOp_o, hz.Flush_o, hz.PipeStall_o, hz.Err_o};
   endfunction
   function automatic logic [47:0] perf();
      return {hz.LoadUseCnt_o, hz.MemWaitCnt_o, hz.FlushCnt_o};
   endfunction
   function automatic logic [47:0] exp_perf();
`ifdef STALL_PERF_EN
      return {16'(m_lu), 16'(m_mw), 16'(m_fl)};
`else
      return 48'd0;
`endif
   endfunction
   task automatic set_in(input logic [4:0] rs1, rs2, rd, input logic mr, br, rq, ak);
      hz.ID_rs1_i = rs1; hz.ID_rs2_i = rs2; hz.EX_rd_i = rd;
      hz.EX_MemRead_i = mr; hz.Branch_taken_i = br; hz.MEM_req_i = rq; hz.MEM_ack_i = ak;
   endtask
   // advance one clock, applying the memory-wait/timeout rules to the model
   task automatic tick();
      logic [7:0] e;
      e = model_out();
      @(posedge clk);
      if (rst) begin
         m_waited = 0; m_err = 0; m_lu = 0; m_mw = 0; m_fl = 0;
      end else if (!m_err) begin
         if (e[3] && m_lu < 65535) m_lu++;
         if (e[1] && m_mw < 65535) m_mw++;
         if (e[2] && m_fl < 65535) m_fl++;
         if ((m_waited > 0 || hz.MEM_req_i) && !hz.MEM_ack_i) begin
            m_waited++;
            if (m_waited > TO) m_err = 1;
         end else m_waited = 0;
      end
      #1;
   endtask
   task automatic test_reset();
      rst = 1;
      set_in(1, 2, 1, 1, 1, 1, 0);
      tick();
      tick();
      rst = 0;
      set_in(0, 0, 0, 0, 0, 0, 0);
      #4;
      if (obs() !== 8'b00_110000) begin $display("FAIL reset_out got=%b exp=%b", obs(), 8'b00_110000); bad++; end
      total++;
      if (perf() !== 48'd0) begin $display("FAIL reset_perf got=%h exp=0", perf()); bad++; end
      total++;
      tick();
   endtask
   task automatic test_load_use();
      set_in(3, 5, 5, 1, 0, 0, 0);
      #4;
      if (obs() !== 8'b00_001000) begin $display("FAIL load_use got=%b exp=%b", obs(), 8'b00_001000); bad++; end
      total++;
      tick();
      set_in(3, 5, 5, 0, 0, 0, 0);
      #4;
      if (obs() !== 8'b00_110000) begin $display("FAIL load_use_clear got=%b exp=%b", obs(), 8'b00_110000); bad++; end
      total++;
      tick();
      set_in(0, 7, 0, 1, 0, 0, 0);
      #4;
      if (obs() !== 8'b00_110000) begin $display("FAIL zero_reg got=%b exp=%b", obs(), 8'b00_110000); bad++; end
      total++;
      tick();
   endtask
   task automatic test_mem_wait();
      logic [7:0] want;
      set_in(0, 0, 0, 0, 0, 1, 0);
      for (int i = 0; i < 3; i++) begin
         #4;
         want = {(i == 0) ? 2'd0 : 2'd1, 6'b000010};
         if (obs() !== want) begin $display("FAIL mem_wait_%0d got=%b exp=%b", i, obs(), want); bad++; end
         total++;
         tick();
      end
      hz.MEM_ack_i = 1;
      #4;
      if (obs() !== 8'b01_110000) begin $display("FAIL mem_ack got=%b exp=%b", obs(), 8'b01_110000); bad++; end
      total++;
      tick();
      set_in(0, 0, 0, 0, 0, 0, 0);
      #4;
      if (obs() !== 8'b00_110000) begin $display("FAIL mem_release got=%b exp=%b", obs(), 8'b00_110000); bad++; end
      total++;
      if (perf() !== exp_perf()) begin $display("FAIL mem_perf got=%h exp=%h", perf(), exp_perf()); bad++; end
      total++;
      tick();
   endtask
   task automatic test_timeout();
      set_in(0, 0, 0, 0, 0, 1, 0);
      for (int i = 0; i <= TO; i++) tick();
      set_in(0, 0, 0, 0, 1, 0, 1);
      #4;
      if (obs() !== 8'b10_000011) begin $display("FAIL timeout_err got=%b exp=%b", obs(), 8'b10_000011); bad++; end
      total++;
      tick();
      tick();
      #4;
      if (obs() !== 8'b10_000011) begin $display("FAIL err_sticky got=%b exp=%b", obs(), 8'b10_000011); bad++; end
      total++;
      rst = 1;
      tick();
      rst = 0;
      set_in(0, 0, 0, 0, 0, 0, 0);
      #4;
      if (obs() !== 8'b00_110000) begin $display("FAIL err_reset got=%b exp=%b", obs(), 8'b00_110000); bad++; end
      total++;
      tick();
   endtask
   task automatic test_priority();
      set_in(4, 0, 4, 1, 1, 0, 0);
      #4;
      if (obs() !== 8'b00_001000) begin $display("FAIL lu_over_branch got=%b exp=%b", obs(), 8'b00_001000); bad++; end
      total++;
      tick();
      set_in(4, 0, 4, 1, 1, 1, 0);
      #4;
      if (obs() !== 8'b00_000010) begin $display("FAIL mw_over_all got=%b exp=%b", obs(), 8'b00_000010); bad++; end
      total++;
      tick();
      set_in(0, 0, 0, 0, 1, 1, 1);
      #4;
      if (obs() !== 8'b01_110100) begin $display("FAIL branch_after_ack got=%b exp=%b", obs(), 8'b01_110100); bad++; end
      total++;
      tick();
   endtask
   task automatic test_branch();
      rst = 1;
      tick();
      rst = 0;
      set_in(0, 0, 0, 0, 1, 0, 0);
      #4;
      if (obs() !== 8'b00_110100) begin $display("FAIL branch got=%b exp=%b", obs(), 8'b00_110100); bad++; end
      total++;
      tick();
      set_in(0, 0, 0, 0, 0, 0, 0);
      #4;
`ifdef STALL_PERF_EN
      if (hz.FlushCnt_o !== 16'd1) begin $display("FAIL flush_cnt got=%0d exp=1", hz.FlushCnt_o); bad++; end
`else
      if (hz.FlushCnt_o !== 16'd0) begin $display("FAIL flush_cnt got=%0d exp=0", hz.FlushCnt_o); bad++; end
`endif
      total++;
      tick();
   endtask
   task automatic test_random();
      for (int i = 0; i < 400; i++) begin
         rst = ($urandom_range(59) == 0);
         set_in(5'($urandom_range(3)), 5'($urandom_range(3)), 5'($urandom_range(3)),
                1'($urandom), 1'($urandom), 1'($urandom_range(3) == 0), 1'($urandom_range(2) == 0));
         #4;
         if (obs() !== model_out()) begin $display("FAIL rand_out cyc=%0d got=%b exp=%b", i, obs(), model_out()); bad++; end
         total++;
         if (perf() !== exp_perf()) begin $display("FAIL rand_perf cyc=%0d got=%h exp=%h", i, perf(), exp_perf()); bad++; end
         total++;
         tick();
      end
      rst = 0;
   endtask
   initial begin
      set_in(0, 0, 0, 0, 0, 0, 0);
      test_reset();
      test_load_use();
      test_mem_wait();
      test_timeout();
      test_priority();
      test_branch();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
